merge_pass_sched: RTL

//  Sequences the bottom-up merge-sort passes over the ping/pong dual-bank pair memory once sort_16 has left sorted runs of INIT_RUN pairs.
//  Per pass it walks the array, issues one merge command per pair of adjacent runs to the merge datapath, and waits for completion.

---
 rtl/merge_pass_sched_pkg.sv | 39 +++
 rtl/merge_pass_sched_run_calc.sv | 42 ++++
 rtl/merge_pass_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/merge_pass_sched_pkg.sv
// Shared types for the merge-pass scheduler.
// Provides the merge command layout, whose field widths come from
// BANK_ADDR_WIDTH, the default initial run length, and the FSM state encoding.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 10
`endif
`ifndef MSCHED_INIT_RUN
`define MSCHED_INIT_RUN 16
`endif

package merge_pass_sched_pkg;

  // Pair-index width of one bank
  localparam int unsigned BANK_AW = `BANK_ADDR_WIDTH;

  // Length of the sorted runs left behind by the 16-element presort
  localparam int unsigned INIT_RUN_DEF = `MSCHED_INIT_RUN;

  // One merge command. The lengths and b_base need one extra bit.
  // a_len and b_len can reach 2^BANK_AW.
  // b_base can point one run past the end of the array when b_len is 0.
  typedef struct packed {
    logic               src_sel;
    logic [BANK_AW-1:0] a_base;
    logic [BANK_AW:0]   a_len;
    logic [BANK_AW:0]   b_base;
    logic [BANK_AW:0]   b_len;
    logic [BANK_AW-1:0] dst_base;
  } merge_cmd_t;

  // Scheduler states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PLAN  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/merge_pass_sched_run_calc.sv
// msched_run_calc: combinational geometry of one merge command.
// Given the current base, run length and total count, it produces:
//   - the clamped length of run A,
//   - the start of run B,
//   - the clamped length of run B.
// All inputs are W = ADDR_W+2 bits wide, so the sums cannot wrap.
// The outputs drop the top bit, which is always zero while a command is being planned.
module msched_run_calc #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] base_in,
  input  logic [W-1:0] run_in,
  input  logic [W-1:0] count_in,
  output logic [W-2:0] a_len_out,
  output logic [W-2:0] b_base_out,
  output logic [W-2:0] b_len_out
);

  logic [W-1:0] rem_a;
  logic [W-1:0] rem_b;
  logic [W-1:0] b_base_full;
  logic [W-1:0] a_len_full;
  logic [W-1:0] b_len_full;

  // Remaining pairs after each run start, floored at zero, then min'd with run
  always_comb begin
    rem_a       = (count_in > base_in) ? (count_in - base_in) : '0;
    b_base_full = base_in + run_in;
    rem_b       = (count_in > b_base_full) ? (count_in - b_base_full) : '0;
    a_len_full  = (run_in < rem_a) ? run_in : rem_a;
    b_len_full  = (run_in < rem_b) ? run_in : rem_b;
  end

  assign a_len_out  = a_len_full[W-2:0];
  assign b_base_out = b_base_full[W-2:0];
  assign b_len_out  = b_len_full[W-2:0];

  // The MSBs only exist to keep the arithmetic wrap-free
  logic unused_msbs;
  assign unused_msbs = ^{a_len_full[W-1], b_base_full[W-1], b_len_full[W-1]};

endmodule

// File: rtl/merge_pass_sched.sv
// merge_pass_sched: bottom-up merge-sort pass sequencer.
//
// Each pass walks the array and issues one merge command per pair of
// adjacent runs, keeping exactly one command outstanding at a time.
// Between passes it doubles the run length and swaps the ping/pong banks.
// When it finishes, it reports which bank holds the sorted data.
//
// Optional feature macro: MERGE_SCHED_STATS_EN.
//   When defined, the module builds a pass counter and a cycle counter.
//   When undefined, both statistic ports are tied to zero.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 10
`endif
`ifndef MSCHED_INIT_RUN
`define MSCHED_INIT_RUN 16
`endif

module merge_pass_sched
  import merge_pass_sched_pkg::*;
#(
  parameter int unsigned ADDR_W   = `BANK_ADDR_WIDTH,
  parameter int unsigned INIT_RUN = `MSCHED_INIT_RUN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_in,
  input  logic [ADDR_W:0]   count_in,
  output logic              cmd_valid_out,
  input  logic              cmd_ready_in,
  output merge_cmd_t        cmd_out,
  input  logic              merge_done_in,
  output logic              done_out,
  output logic              result_sel_out,
  output logic              err_out,
  output logic [7:0]        pass_cnt_out,
  output logic [31:0]       cycle_cnt_out
);

  // Two spare bits, so that base + 2*run cannot wrap even at count = 2^ADDR_W
  localparam int unsigned W = ADDR_W + 2;
  localparam logic [W-1:0] INIT_RUN_W = W'(INIT_RUN);

  logic [2:0]   state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] run_q, run_d;
  logic [W-1:0] base_q, base_d;
  logic         src_q, src_d;
  logic         done_q, done_d;
  logic         result_sel_q, result_sel_d;
  logic         err_q, err_d;
  merge_cmd_t   cmd_q, cmd_d;

  logic [W-2:0] calc_a_len;
  logic [W-2:0] calc_b_base;
  logic [W-2:0] calc_b_len;
  logic [W-1:0] count_ext;
  logic [W-1:0] run_dbl;
  logic [W-1:0] base_step;
  logic         start_ok;
  logic         busy;

  assign count_ext = {1'b0, count_in};
  assign run_dbl   = run_q << 1;
  assign base_step = base_q + run_dbl;
  assign start_ok  = start_in && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign busy      = (state_q == ST_PLAN) || (state_q == ST_ISSUE) ||
                     (state_q == ST_WAIT) || (state_q == ST_NEXT);

  msched_run_calc #(
    .W (W)
  ) u_run_calc (
    .base_in    (base_q),
    .run_in     (run_q),
    .count_in   (count_q),
    .a_len_out  (calc_a_len),
    .b_base_out (calc_b_base),
    .b_len_out  (calc_b_len)
  );

  // Next-state logic: FSM transitions, pass geometry and the command register
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    run_d        = run_q;
    base_d       = base_q;
    src_d        = src_q;
    done_d       = done_q;
    result_sel_d = result_sel_q;
    cmd_d        = cmd_q;
    // A completion pulse is only meaningful while a command is outstanding
    err_d        = err_q | (merge_done_in && (state_q != ST_WAIT));

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          count_d      = count_ext;
          run_d        = INIT_RUN_W;
          base_d       = '0;
          src_d        = 1'b0;
          result_sel_d = 1'b0;
          // A single presorted run (or an empty array) is already sorted in ping
          if (count_ext <= INIT_RUN_W) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PLAN;
            done_d  = 1'b0;
          end
        end
      end

      ST_PLAN: begin
        cmd_d.src_sel  = src_q;
        cmd_d.a_base   = base_q[ADDR_W-1:0];
        cmd_d.a_len    = calc_a_len;
        cmd_d.b_base   = calc_b_base;
        cmd_d.b_len    = calc_b_len;
        cmd_d.dst_base = base_q[ADDR_W-1:0];
        state_d        = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (cmd_ready_in) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (merge_done_in) begin
          base_d  = base_step;
          state_d = (base_step < count_q) ? ST_PLAN : ST_NEXT;
        end
      end

      ST_NEXT: begin
        run_d  = run_dbl;
        src_d  = ~src_q;
        base_d = '0;
        // The pass just finished wrote into the other bank, which now holds the result
        if (run_dbl >= count_q) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          result_sel_d = ~src_q;
        end else begin
          state_d = ST_PLAN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers. A reset aborts any sort in progress immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      run_q        <= '0;
      base_q       <= '0;
      src_q        <= 1'b0;
      done_q       <= 1'b0;
      result_sel_q <= 1'b0;
      err_q        <= 1'b0;
      cmd_q        <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      run_q        <= run_d;
      base_q       <= base_d;
      src_q        <= src_d;
      done_q       <= done_d;
      result_sel_q <= result_sel_d;
      err_q        <= err_d;
      cmd_q        <= cmd_d;
    end
  end

  assign cmd_valid_out  = (state_q == ST_ISSUE);
  assign cmd_out        = cmd_q;
  assign done_out       = done_q;
  assign result_sel_out = result_sel_q;
  assign err_out        = err_q;

`ifdef MERGE_SCHED_STATS_EN
  logic [7:0]  pass_cnt_q, pass_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  // Statistics: saturating pass count; the cycle count runs while busy and freezes in DONE
  always_comb begin
    pass_cnt_d  = pass_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if (start_ok) begin
      pass_cnt_d  = '0;
      cycle_cnt_d = '0;
    end else begin
      if ((state_q == ST_NEXT) && (pass_cnt_q != 8'hFF)) begin
        pass_cnt_d = pass_cnt_q + 8'd1;
      end
      if (busy) begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
    end
  end

  // Statistic registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pass_cnt_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      pass_cnt_q  <= pass_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign pass_cnt_out  = pass_cnt_q;
  assign cycle_cnt_out = cycle_cnt_q;
`else
  assign pass_cnt_out  = 8'd0;
  assign cycle_cnt_out = 32'd0;

  // start_ok and busy only feed the statistics counters
  logic unused_stats;
  assign unused_stats = start_ok ^ busy;
`endif

endmodule
